// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared constants for the pipeline hazard controller: controller state
// encoding, the active level used when holding a stage, and the default
// redirect address width.
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int PHC_ADDR_WIDTH = 32;

    typedef logic [1:0] phc_state_t;

    localparam phc_state_t ST_RUN  = 2'd0;
    localparam phc_state_t ST_PEND = 2'd1;
    localparam phc_state_t ST_HALT = 2'd2;

    // Level driven onto a stall_out bit to hold that stage.
    localparam logic STOP_LVL = 1'b1;

    // Watchdog counter width; covers TIMEOUT values up to 65535.
    localparam int PHC_WD_W = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_prio_enc.sv
// ----------------------------------------------------------------------------
// pipe_prio_enc
// Highest-set-bit encoder. Higher indices are older pipeline stages, so the
// highest set bit is the oldest requester.
//   vec_i   [WIDTH]  request vector
//   idx_o   [IDX_W]  index of highest set bit (0 when none set)
//   valid_o          at least one bit of vec_i is set
// ----------------------------------------------------------------------------
module pipe_prio_enc #(
    parameter int WIDTH = 6,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Ascending scan: the last hit is the highest index.
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline hazard controller: turns per-stage stall / redirect requests and
// a debug halt request into hold, bubble and squash masks plus a PC redirect,
// with a stall watchdog and optional performance counters.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//   defined   -> 32-bit wrapping stall-cycle and flush counters
//   undefined -> perf ports tied to zero, no counter flops
//
// Ports
//   clk_in                 clock, rising edge
//   reset_n_in             asynchronous active-low reset
//   stall_req_in   [S]     stage k cannot advance
//   redir_req_in   [S]     stage k requests a redirect
//   redir_addr_in  [S*A]   redirect target, slice k for stage k
//   halt_req_in            level debug halt request
//   new_pc_ready_in        front end accepts new_pc_out
//   stall_out      [S]     hold mask
//   bubble_out     [S]     insert-NOP mask
//   flush_out      [S]     squash mask
//   new_pc_valid_out       redirect valid toward PC stage
//   new_pc_out     [A]     redirect target
//   halted_out             controller is halted
//   stall_timeout_out      one-cycle watchdog pulse
//   perf_stall_cycles_out  [32] counted stall cycles
//   perf_flush_count_out   [32] accepted redirects
//
// State | meaning
// RUN   | normal operation, redirects delivered combinationally
// PEND  | redirect accepted but front end not ready; target held, PC held
// HALT  | debug halt, whole pipe held, redirects ignored
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STAGES     = 6,
    parameter int ADDR_WIDTH = PHC_ADDR_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk_in,
    input  logic                         reset_n_in,
    input  logic [STAGES-1:0]            stall_req_in,
    input  logic [STAGES-1:0]            redir_req_in,
    input  logic [STAGES*ADDR_WIDTH-1:0] redir_addr_in,
    input  logic                         halt_req_in,
    input  logic                         new_pc_ready_in,
    output logic [STAGES-1:0]            stall_out,
    output logic [STAGES-1:0]            bubble_out,
    output logic [STAGES-1:0]            flush_out,
    output logic                         new_pc_valid_out,
    output logic [ADDR_WIDTH-1:0]        new_pc_out,
    output logic                         halted_out,
    output logic                         stall_timeout_out,
    output logic [31:0]                  perf_stall_cycles_out,
    output logic [31:0]                  perf_flush_count_out
);

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [PHC_WD_W-1:0] TO_VAL = PHC_WD_W'(TIMEOUT);
    localparam logic [PHC_WD_W-1:0] TO_M1  = PHC_WD_W'(TIMEOUT - 1);

    phc_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pend_addr_q, pend_addr_d;
    logic [PHC_WD_W-1:0]      wd_q, wd_d;

    logic [IDX_W-1:0]         stall_idx, redir_idx;
    logic                     stall_any, redir_any;
    logic [STAGES-1:0]        upto_stall, upto_redir;
    logic [ADDR_WIDTH-1:0]    redir_tgt;

    logic                     in_halt, in_pend;
    logic                     redir_ok;
    logic                     run_stall_act;
    logic [STAGES-1:0]        stall_int, bubble_int, flush_int;
    logic                     npc_valid_int;
    logic [ADDR_WIDTH-1:0]    npc_int;
    logic                     wd_inc, timeout_int;

    pipe_prio_enc #(.WIDTH(STAGES), .IDX_W(IDX_W)) u_stall_enc (
        .vec_i   (stall_req_in),
        .idx_o   (stall_idx),
        .valid_o (stall_any)
    );

    pipe_prio_enc #(.WIDTH(STAGES), .IDX_W(IDX_W)) u_redir_enc (
        .vec_i   (redir_req_in),
        .idx_o   (redir_idx),
        .valid_o (redir_any)
    );

    // Thermometer masks [idx:0] and target slice of the winning redirect.
    always_comb begin
        upto_stall = '0;
        upto_redir = '0;
        redir_tgt  = '0;
        for (int i = 0; i < STAGES; i++) begin
            upto_stall[i] = stall_any && (i <= int'(stall_idx));
            upto_redir[i] = redir_any && (i <= int'(redir_idx));
            if (IDX_W'(i) == redir_idx) begin
                redir_tgt = redir_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign in_halt = (state_q == ST_HALT);
    assign in_pend = (state_q == ST_PEND);

    // A redirect is only taken when no older stage is stalled. Once taken,
    // every stall at or below it is squashed anyway, and nothing above it
    // is stalling, so the stall-derived masks collapse to zero.
    assign redir_ok      = redir_any && !in_halt
                           && ((stall_req_in & ~upto_redir) == '0);
    assign run_stall_act = stall_any && !redir_ok;

    always_comb begin
        stall_int     = '0;
        bubble_int    = '0;
        flush_int     = '0;
        npc_valid_int = 1'b0;
        npc_int       = '0;
        if (in_halt) begin
            stall_int = {STAGES{STOP_LVL}};
        end else begin
            if (run_stall_act) begin
                stall_int = upto_stall;
            end
            if (in_pend) begin
                stall_int[0] = STOP_LVL;
            end
            for (int i = 0; i < STAGES; i++) begin
                bubble_int[i] = run_stall_act && (i == int'(stall_idx) + 1);
            end
            if (redir_ok) begin
                flush_int    = upto_redir;
                flush_int[0] = 1'b0;
            end
            npc_valid_int = redir_ok || in_pend;
            if (redir_ok) begin
                npc_int = redir_tgt;
            end else if (in_pend) begin
                npc_int = pend_addr_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            ST_RUN: begin
                if (redir_ok) begin
                    if (!new_pc_ready_in) begin
                        state_d     = ST_PEND;
                        pend_addr_d = redir_tgt;
                    end
                end else if (halt_req_in) begin
                    state_d = ST_HALT;
                end
            end
            ST_PEND: begin
                // Halt waits until the pending redirect has been delivered.
                if (redir_ok) begin
                    pend_addr_d = redir_tgt;
                end
                if (new_pc_ready_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!halt_req_in) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog: counts consecutive stalled non-halt cycles, holds in HALT,
    // saturates at TIMEOUT and pulses on the cycle it arrives there.
    assign wd_inc      = !in_halt && (stall_int != '0);
    assign timeout_int = wd_inc && (wd_q == TO_M1);

    always_comb begin
        wd_d = wd_q;
        if (!in_halt) begin
            if (!wd_inc) begin
                wd_d = '0;
            end else if (wd_q != TO_VAL) begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_RUN;
            pend_addr_q <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            wd_q        <= wd_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (wd_inc) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redir_ok) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles_out = perf_stall_q;
    assign perf_flush_count_out  = perf_flush_q;
`else
    assign perf_stall_cycles_out = '0;
    assign perf_flush_count_out  = '0;
`endif

    // Outputs are forced low while reset is asserted, independent of the
    // request inputs, so a reset mid-halt or mid-redirect releases the pipe
    // immediately.
    assign stall_out         = reset_n_in ? stall_int     : '0;
    assign bubble_out        = reset_n_in ? bubble_int    : '0;
    assign flush_out         = reset_n_in ? flush_int     : '0;
    assign new_pc_valid_out  = reset_n_in ? npc_valid_int : 1'b0;
    assign new_pc_out        = reset_n_in ? npc_int       : '0;
    assign halted_out        = reset_n_in ? in_halt       : 1'b0;
    assign stall_timeout_out = reset_n_in ? timeout_int   : 1'b0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int ST = 6;
    localparam int AW = 32;
    localparam int TO = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ST-1:0]     stall_req, redir_req;
    logic [ST*AW-1:0]  redir_addr;
    logic              halt_req, ready;
    logic [ST-1:0]     stall_o, bubble_o, flush_o;
    logic              npv_o, halted_o, to_o;
    logic [AW-1:0]     npc_o;
    logic [31:0]       pstall_o, pflush_o;

    pipe_hazard_ctrl #(.STAGES(ST), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_in                (clk),
        .reset_n_in            (rst_n),
        .stall_req_in          (stall_req),
        .redir_req_in          (redir_req),
        .redir_addr_in         (redir_addr),
        .halt_req_in           (halt_req),
        .new_pc_ready_in       (ready),
        .stall_out             (stall_o),
        .bubble_out            (bubble_o),
        .flush_out             (flush_o),
        .new_pc_valid_out      (npv_o),
        .new_pc_out            (npc_o),
        .halted_out            (halted_o),
        .stall_timeout_out     (to_o),
        .perf_stall_cycles_out (pstall_o),
        .perf_flush_count_out  (pflush_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: controller described by flags, not by state codes.
    bit          m_halted, m_pend;
    logic [AW-1:0] m_paddr;
    int          m_wd;
    logic [31:0] m_pstall, m_pflush;

    logic [ST-1:0] e_stall, e_bub, e_flush;
    logic          e_npv, e_to, e_acc;
    logic [AW-1:0] e_npc;

    function automatic int hi_idx(input logic [ST-1:0] v);
        int h = -1;
        for (int i = 0; i < ST; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_reset;
        m_halted = 0; m_pend = 0; m_paddr = '0; m_wd = 0;
        m_pstall = '0; m_pflush = '0;
    endtask

    task automatic model_eval;
        int k, r, ks;
        k = hi_idx(stall_req);
        r = hi_idx(redir_req);
        e_stall = '0; e_bub = '0; e_flush = '0; e_npv = 0; e_npc = '0; e_to = 0;
        e_acc = !m_halted && (r >= 0) && (k <= r);
        if (m_halted) begin
            e_stall = '1;
        end else begin
            ks = e_acc ? -1 : k;
            for (int i = 0; i <= ks; i++) e_stall[i] = 1'b1;
            if (m_pend) e_stall[0] = 1'b1;
            if (ks >= 0 && ks + 1 < ST) e_bub[ks+1] = 1'b1;
            if (e_acc) for (int i = 1; i <= r; i++) e_flush[i] = 1'b1;
            e_npv = e_acc || m_pend;
            if (e_acc) e_npc = redir_addr[r*AW +: AW];
            else if (m_pend) e_npc = m_paddr;
            e_to = (e_stall != '0) && (m_wd == TO - 1);
        end
    endtask

    task automatic model_commit;
        if (m_halted) begin
            m_halted = halt_req;
        end else begin
            if (e_stall != '0) begin
                m_pstall++;
                m_wd = (m_wd < TO) ? m_wd + 1 : TO;
            end else begin
                m_wd = 0;
            end
            if (e_acc) m_pflush++;
            if (m_pend) begin
                if (e_acc) m_paddr = e_npc;
                if (ready) m_pend = 0;
            end else if (e_acc) begin
                if (!ready) begin m_pend = 1; m_paddr = e_npc; end
            end else if (halt_req) begin
                m_halted = 1;
            end
        end
    endtask

    task automatic check_all(input string p);
        chk({p, ".stall"},  64'(stall_o),  64'(e_stall));
        chk({p, ".bubble"}, 64'(bubble_o), 64'(e_bub));
        chk({p, ".flush"},  64'(flush_o),  64'(e_flush));
        chk({p, ".npv"},    64'(npv_o),    64'(e_npv));
        chk({p, ".npc"},    64'(npc_o),    64'(e_npc));
        chk({p, ".halted"}, 64'(halted_o), 64'(m_halted));
        chk({p, ".tmo"},    64'(to_o),     64'(e_to));
        chk({p, ".pstall"}, 64'(pstall_o), PERF ? 64'(m_pstall) : 64'd0);
        chk({p, ".pflush"}, 64'(pflush_o), PERF ? 64'(m_pflush) : 64'd0);
    endtask

    task automatic check_zero(input string p);
        chk({p, ".stall"},  64'(stall_o),  64'd0);
        chk({p, ".bubble"}, 64'(bubble_o), 64'd0);
        chk({p, ".flush"},  64'(flush_o),  64'd0);
        chk({p, ".npv"},    64'(npv_o),    64'd0);
        chk({p, ".npc"},    64'(npc_o),    64'd0);
        chk({p, ".halted"}, 64'(halted_o), 64'd0);
        chk({p, ".tmo"},    64'(to_o),     64'd0);
        chk({p, ".pstall"}, 64'(pstall_o), 64'd0);
        chk({p, ".pflush"}, 64'(pflush_o), 64'd0);
    endtask

    // One clock: drive at the falling edge, check, advance the model.
    task automatic cycle(input string p, input logic [ST-1:0] s, input logic [ST-1:0] r,
                         input logic h, input logic rd, input logic [ST*AW-1:0] a);
        @(negedge clk);
        rst_n = 1'b1;
        stall_req = s; redir_req = r; halt_req = h; ready = rd; redir_addr = a;
        #1;
        model_eval;
        check_all(p);
        model_commit;
    endtask

    // Asynchronous reset in the middle of a cycle; released by the next cycle().
    task automatic do_reset(input string p);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(p);
        model_reset;
    endtask

    logic [ST*AW-1:0] addr_v;
    bit               hold_halt;

    initial begin
        rst_n = 1'b0;
        stall_req = '1; redir_req = '1; halt_req = 1'b1; ready = 1'b0;
        for (int j = 0; j < ST; j++) addr_v[j*AW +: AW] = $urandom;
        redir_addr = addr_v;
        #3;
        check_zero("por");
        model_reset;

        // Single stall at stage 2
        cycle("stall2", 6'b000100, '0, 1'b0, 1'b1, addr_v);
        chk("stall2.mask", 64'(stall_o), 64'(6'b000111));
        chk("stall2.bub",  64'(bubble_o), 64'(6'b001000));
        chk("stall2.fl",   64'(flush_o), 64'd0);

        // Redirect from stage 3, front end ready
        addr_v[3*AW +: AW] = 32'h0000_0400;
        cycle("rd3", '0, 6'b001000, 1'b0, 1'b1, addr_v);
        chk("rd3.flush", 64'(flush_o), 64'(6'b001110));
        chk("rd3.npc",   64'(npc_o),   64'h400);
        cycle("rd3.after", '0, '0, 1'b0, 1'b1, addr_v);
        chk("rd3.run", 64'(npv_o), 64'd0);

        // Redirect from stage 3 while the front end is busy
        cycle("pend.acc", '0, 6'b001000, 1'b0, 1'b0, addr_v);
        for (int i = 0; i < 3; i++) begin
            cycle("pend.hold", '0, '0, 1'b0, 1'b0, addr_v);
            chk("pend.pc_hold", 64'(stall_o[0]), 64'd1);
            chk("pend.npc", 64'(npc_o), 64'h400);
        end
        cycle("pend.rel", '0, '0, 1'b0, 1'b1, addr_v);
        cycle("pend.run", '0, '0, 1'b0, 1'b1, addr_v);
        chk("pend.done", 64'(npv_o), 64'd0);

        // Two redirects blocked by an older stall, then stage 4 wins
        addr_v[2*AW +: AW] = 32'h0000_0200;
        addr_v[4*AW +: AW] = 32'h0000_0800;
        cycle("blk", 6'b100000, 6'b010100, 1'b0, 1'b1, addr_v);
        chk("blk.stall", 64'(stall_o), 64'(6'b111111));
        chk("blk.npv",   64'(npv_o),   64'd0);
        cycle("win", '0, 6'b010100, 1'b0, 1'b1, addr_v);
        chk("win.npc",   64'(npc_o),   64'h800);
        chk("win.flush", 64'(flush_o), 64'(6'b011110));

        // Watchdog: stall at stage 1 for 6 cycles, pulse only in the 4th
        cycle("wd.idle", '0, '0, 1'b0, 1'b1, addr_v);
        for (int i = 0; i < 6; i++) begin
            cycle("wd", 6'b000010, '0, 1'b0, 1'b1, addr_v);
            chk("wd.pulse", 64'(to_o), (i == 3) ? 64'd1 : 64'd0);
        end
        cycle("wd.clr", '0, '0, 1'b0, 1'b1, addr_v);

        // Halt, release, halt again, then reset while halted
        cycle("h.req", '0, '0, 1'b1, 1'b1, addr_v);
        cycle("h.in", 6'b000001, 6'b000100, 1'b1, 1'b1, addr_v);
        chk("h.stall",  64'(stall_o),  64'(6'b111111));
        chk("h.halted", 64'(halted_o), 64'd1);
        cycle("h.drop", '0, '0, 1'b0, 1'b1, addr_v);
        cycle("h.run",  '0, '0, 1'b1, 1'b1, addr_v);
        cycle("h.again", 6'b001000, '0, 1'b1, 1'b0, addr_v);
        do_reset("h.rst");

        // Reset while a redirect is pending
        cycle("p.acc", '0, 6'b000010, 1'b0, 1'b0, addr_v);
        cycle("p.in", '0, '0, 1'b1, 1'b0, addr_v);
        do_reset("p.rst");

        // Randomized traffic against the model
        hold_halt = 0;
        for (int n = 0; n < 2000; n++) begin
            logic [ST-1:0] s, r;
            logic rd;
            s = ($urandom_range(0, 2) == 0) ? ST'($urandom) : '0;
            r = ($urandom_range(0, 2) == 0) ? ST'($urandom) : '0;
            if ($urandom_range(0, 19) == 0) hold_halt = !hold_halt;
            rd = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < ST; j++) addr_v[j*AW +: AW] = $urandom;
            cycle("rnd", s, r, hold_halt, rd, addr_v);
            if ($urandom_range(0, 249) == 0) do_reset("rnd.rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 6: pipeline register count; bit 0 = PC, bit 1 = IF_ID, ascending toward WB.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: redirect address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: consecutive stall cycles before the watchdog fires; legal range 1..65535.
REQ-004 clk_in  input  1  sole clock; all state is updated on the rising edge.
REQ-005 reset_n_in  input  1  asynchronous, active-low reset.
REQ-006 stall_req_in  input  STAGES  per-stage stall request; bit k means stage k cannot advance.
REQ-007 redir_req_in  input  STAGES  per-stage redirect (jump/trap) request.
REQ-008 redir_addr_in  input  STAGES*ADDR_WIDTH  redirect targets; slice k belongs to stage k.
REQ-009 halt_req_in  input  1  level-sensitive debug halt request.
REQ-010 new_pc_ready_in  input  1  front end accepts new_pc_out.
REQ-011 stall_out  output  STAGES  hold mask.
REQ-012 bubble_out  output  STAGES  insert-NOP mask.
REQ-013 flush_out  output  STAGES  squash mask.
REQ-014 new_pc_valid_out / new_pc_out  output  1 / ADDR_WIDTH  redirect to PC stage.
REQ-015 halted_out, stall_timeout_out  output  1 each  halt status; one-cycle watchdog pulse.
REQ-016 perf_stall_cycles_out, perf_flush_count_out  output  32 each  performance counters.

Function
REQ-017 Stall: k = highest index with stall_req_in set; SHALL drive stall_out[k:0]=1 and bubble_out[k+1]=1 when k+1<STAGES; this is combinational.
REQ-018 Redirect: r = highest index with redir_req_in set (oldest wins); SHALL be accepted only if no stall_req_in bit above r is set, otherwise ignored that cycle.
REQ-019 On accept: flush_out[r:1]=1 in the same cycle; stall requests at index <= r SHALL be masked; new_pc_valid_out=1 and new_pc_out=slice r, both combinational.
REQ-020 FSM states RUN, PEND, HALT.
REQ-021 RUN->PEND when a redirect is accepted with new_pc_ready_in=0; the address SHALL be latched.
REQ-022 In PEND: new_pc_valid_out=1 with the latched address and stall_out[0]=1; an older accepted redirect SHALL overwrite the latch and flush; PEND->RUN on new_pc_ready_in=1.
REQ-023 RUN->HALT when halt_req_in=1 and no redirect is being accepted. HALT entry SHALL be deferred while in PEND.
REQ-024 In HALT: stall_out all ones, flush/bubble zero, halted_out=1; redirects ignored; HALT->RUN the cycle after halt_req_in=0.
REQ-025 Watchdog counter SHALL increment each non-HALT cycle in which any stall_out bit is set.
REQ-026 The counter SHALL clear on any cycle with no stall and saturate at TIMEOUT.
REQ-027 stall_timeout_out SHALL pulse exactly in the cycle the counter reaches TIMEOUT.
REQ-028 Perf counters SHALL wrap modulo 2^32: stall cycles counts REQ-025 cycles; flush count increments per accepted redirect.

Reset
REQ-029 During reset: state=RUN, latch, watchdog and perf counters zero, all outputs zero.
REQ-030 Reset assertion mid-PEND or mid-HALT SHALL discard the pending redirect or halt immediately, asynchronously.

Configuration
REQ-031 Macro PIPE_HAZARD_CTRL_PERF_EN: when defined, perf counters are implemented per REQ-028.
REQ-032 When PIPE_HAZARD_CTRL_PERF_EN is undefined, the perf ports remain and are tied to zero, and no counter flops exist.

Structure
REQ-033 State encoding (RUN=2'd0, PEND=2'd1, HALT=2'd2) and the STOP level constant SHALL live in the shared defines/package, alongside ADDR_WIDTH.
REQ-034 Sub-module pipe_prio_enc SHALL compute highest-set index and valid for a STAGES-wide vector; it is instantiated twice (stall, redirect).

Verification
REQ-035 stall_req_in=6'b000100 -> stall_out=6'b000111, bubble_out=6'b001000, flush_out=0.
REQ-036 redir_req_in=6'b001000, slice3=32'h0000_0400, ready=1 -> flush_out=6'b001110, new_pc_out=32'h400, state stays RUN, flush count +1.
REQ-037 Redirect at stage 3 with ready=0 for 3 cycles -> PEND; stall_out[0]=1 and new_pc_out=32'h400 held 3 cycles; RUN after ready=1.
REQ-038 Redirects at stages 2 and 4 together, stall_req_in=6'b100000 -> both ignored, stall_out=6'b111111; next cycle with stall removed, stage 4 wins.
REQ-039 TIMEOUT=4, stall_req_in[1] held 6 cycles -> stall_timeout_out high only in cycle 4; perf stall cycles=6.
REQ-040 halt_req_in=1 during RUN -> next cycle stall_out=6'b111111, halted_out=1; reset_n_in=0 mid-halt -> all outputs 0 immediately.
